lfsr_rng_scheduler: RTL and testbench

- Shares one maximal-length LFSR random source between N_REQ requesters using round-robin arbitration.
- Each accepted request returns the current LFSR word and advances the LFSR by one step.
- Also sequences reseeding: load a seed, then run a warm-up of discarded steps before serving requesters again.
- Sits between the LFSR datapath and its consumers (scramblers, test-pattern and noise generators).

---
 rtl/lfsr_pkg.sv | 57 +++++
 rtl/lfsr_rng_scheduler_core.sv | 40 ++++
 rtl/lfsr_rng_scheduler.sv | 114 +++++++++++
 tb/tb_lfsr_rng_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random-number scheduler: tap table,
// scheduler state type and the single-step next-state helper.
package lfsr_pkg;

  localparam int LFSR_MAX_WIDTH = 32;

  typedef enum logic {
    RUN    = 1'b0,
    WARMUP = 1'b1
  } lfsr_sched_state_e;

  // Maximal-length feedback masks; bit k set means state bit k feeds the XOR.
  function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_taps(input int width);
    case (width)
      3:  return 32'h0000_0006;
      4:  return 32'h0000_000C;
      5:  return 32'h0000_0014;
      6:  return 32'h0000_0030;
      7:  return 32'h0000_0060;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      25: return 32'h0120_0000;
      26: return 32'h0200_0023;
      27: return 32'h0400_0013;
      28: return 32'h0900_0000;
      29: return 32'h1400_0000;
      30: return 32'h2000_0029;
      31: return 32'h4800_0000;
      32: return 32'h8020_0003;
      default: return '0;
    endcase
  endfunction

  // Callers truncate the result to their own width; taps never exceed it.
  function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_advance(
    input logic [LFSR_MAX_WIDTH-1:0] state,
    input logic [LFSR_MAX_WIDTH-1:0] taps
  );
    return {state[LFSR_MAX_WIDTH-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_rng_scheduler_core.sv
// LFSR state register: load (with zero-seed substitution) takes priority
// over a single Fibonacci shift-left step.
module lfsr_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);
  import lfsr_pkg::*;

  localparam logic [LFSR_MAX_WIDTH-1:0] TAPS = lfsr_taps(WIDTH);

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] state_next;

  always_comb begin
    state_next = state_reg;
    if (load) begin
      // All-zero is the lock-up state, so a zero seed becomes all ones.
      state_next = (load_val == '0) ? '1 : load_val;
    end else if (step) begin
      state_next = WIDTH'(lfsr_advance(LFSR_MAX_WIDTH'(state_reg), TAPS));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '1;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/lfsr_rng_scheduler.sv
// Round-robin sharing of one LFSR among N_REQ requesters, with seed load
// followed by a warm-up of discarded steps and a period-wrap pulse.
module lfsr_rng_scheduler #(
  parameter int WIDTH  = 16,
  parameter int N_REQ  = 4,
  parameter int WARMUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [WIDTH-1:0] rdata,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic             busy,
  output logic             period_wrap
);
  import lfsr_pkg::*;

  if (WIDTH < 3 || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
    $error("lfsr_rng_scheduler: WIDTH must be in 3..32");
  end
  if (N_REQ < 1 || N_REQ > 16) begin : g_bad_nreq
    $error("lfsr_rng_scheduler: N_REQ must be in 1..16");
  end
  if (WARMUP < 0 || WARMUP > 255) begin : g_bad_warmup
    $error("lfsr_rng_scheduler: WARMUP must be in 0..255");
  end

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [LFSR_MAX_WIDTH-1:0] TAPS = lfsr_taps(WIDTH);
  localparam logic [7:0] WARMUP_CNT = 8'(WARMUP);
  localparam lfsr_sched_state_e ST_RUN    = lfsr_pkg::RUN;
  localparam lfsr_sched_state_e ST_WARMUP = lfsr_pkg::WARMUP;

  lfsr_sched_state_e fsm_reg;
  logic [PTR_W-1:0]  ptr_reg;
  logic [7:0]        wu_cnt_reg;
  logic [WIDTH-1:0]  ref_seed_reg;
  logic              period_wrap_reg;

  logic [WIDTH-1:0]  lfsr_state;
  logic [WIDTH-1:0]  lfsr_next;
  logic [WIDTH-1:0]  seed_val;
  logic [PTR_W:0]    pick;
  logic [PTR_W-1:0]  ptr_next;
  logic              run_grant;
  logic              step;

  // Returns {found, index} of the first set request at or after p, wrapping.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [PTR_W-1:0] p);
    logic [PTR_W:0] result;
    int             cand;
    result = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = int'(p) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (r[PTR_W'(cand)]) result = {1'b1, PTR_W'(cand)};
    end
    return result;
  endfunction

  assign pick      = rr_pick(req, ptr_reg);
  assign run_grant = !rst && !seed_load && (fsm_reg == ST_RUN) && pick[PTR_W];
  assign step      = !seed_load && (run_grant || fsm_reg == ST_WARMUP);
  assign ptr_next  = (pick[PTR_W-1:0] == PTR_W'(N_REQ - 1)) ? '0 : pick[PTR_W-1:0] + 1'b1;
  assign seed_val  = (seed == '0) ? '1 : seed;
  assign lfsr_next = WIDTH'(lfsr_advance(LFSR_MAX_WIDTH'(lfsr_state), TAPS));

  always_comb begin
    gnt = '0;
    if (run_grant) gnt[pick[PTR_W-1:0]] = 1'b1;
  end

  lfsr_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .step    (step),
    .load    (seed_load),
    .load_val(seed),
    .state   (lfsr_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg         <= ST_RUN;
      ptr_reg         <= '0;
      wu_cnt_reg      <= '0;
      ref_seed_reg    <= '1;
      period_wrap_reg <= 1'b0;
    end else begin
      period_wrap_reg <= step && (lfsr_next == ref_seed_reg);
      if (seed_load) begin
        ref_seed_reg <= seed_val;
        wu_cnt_reg   <= WARMUP_CNT;
        fsm_reg      <= (WARMUP > 0) ? ST_WARMUP : ST_RUN;
      end else if (fsm_reg == ST_WARMUP) begin
        // Leaving on count 1 discards exactly WARMUP steps.
        wu_cnt_reg <= wu_cnt_reg - 8'd1;
        if (wu_cnt_reg == 8'd1) fsm_reg <= ST_RUN;
      end else if (run_grant) begin
        ptr_reg <= ptr_next;
      end
    end
  end

  assign rdata       = lfsr_state;
  assign busy        = (fsm_reg == ST_WARMUP);
  assign period_wrap = period_wrap_reg;

endmodule

// File: tb/tb_lfsr_rng_scheduler.sv
// Directed bench for lfsr_rng_scheduler: three instances (16-bit with warm-up,
// 4-bit, 16-bit without warm-up) checked every cycle against a polynomial model.
module tb_lfsr_rng_scheduler;

  logic clk;
  logic rst;

  logic [3:0]  req       [3];
  logic        seed_load [3];
  logic [31:0] seed      [3];

  logic [3:0]  gnt0, gnt1, gnt2;
  logic [15:0] rdata0, rdata2;
  logic [3:0]  rdata1;
  logic        busy0, busy1, busy2;
  logic        wrap0, wrap1, wrap2;

  logic [3:0]  gnt_a   [3];
  logic [31:0] rdata_a [3];
  logic        busy_a  [3];
  logic        wrap_a  [3];

  assign gnt_a[0] = gnt0;
  assign gnt_a[1] = gnt1;
  assign gnt_a[2] = gnt2;
  assign rdata_a[0] = {16'd0, rdata0};
  assign rdata_a[1] = {28'd0, rdata1};
  assign rdata_a[2] = {16'd0, rdata2};
  assign busy_a[0] = busy0;
  assign busy_a[1] = busy1;
  assign busy_a[2] = busy2;
  assign wrap_a[0] = wrap0;
  assign wrap_a[1] = wrap1;
  assign wrap_a[2] = wrap2;

  lfsr_rng_scheduler #(.WIDTH(16), .N_REQ(4), .WARMUP(8)) u_dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .gnt(gnt0), .rdata(rdata0),
    .seed_load(seed_load[0]), .seed(seed[0][15:0]), .busy(busy0), .period_wrap(wrap0)
  );
  lfsr_rng_scheduler #(.WIDTH(4), .N_REQ(4), .WARMUP(0)) u_dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .gnt(gnt1), .rdata(rdata1),
    .seed_load(seed_load[1]), .seed(seed[1][3:0]), .busy(busy1), .period_wrap(wrap1)
  );
  lfsr_rng_scheduler #(.WIDTH(16), .N_REQ(4), .WARMUP(0)) u_dut2 (
    .clk(clk), .rst(rst), .req(req[2]), .gnt(gnt2), .rdata(rdata2),
    .seed_load(seed_load[2]), .seed(seed[2][15:0]), .busy(busy2), .period_wrap(wrap2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h", name, inst, act, exp);
    end
  endtask

  // Model: polynomial recurrences x^16+x^15+x^13+x^4+1 and x^4+x^3+1.
  int m_width [3] = '{16, 4, 16};
  int m_wu_par[3] = '{8, 0, 0};
  logic [31:0] m_state [3];
  logic [31:0] m_ref   [3];
  int          m_ptr   [3];
  int          m_wu    [3];
  int          m_idx   [3];
  logic        m_wrap  [3];

  function automatic logic [31:0] width_mask(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] model_step(input logic [31:0] s, input int w);
    logic fb;
    if (w == 16) fb = s[15] ^ s[14] ^ s[12] ^ s[3];
    else         fb = s[3] ^ s[2];
    return ((s << 1) | {31'd0, fb}) & width_mask(w);
  endfunction

  task automatic model_reset(input int i);
    m_state[i] = width_mask(m_width[i]);
    m_ref[i]   = width_mask(m_width[i]);
    m_ptr[i]   = 0;
    m_wu[i]    = 0;
    m_idx[i]   = -1;
    m_wrap[i]  = 1'b0;
  endtask

  task automatic model_update(input int i);
    logic [31:0] v;
    if (rst) begin
      model_reset(i);
    end else if (seed_load[i]) begin
      v = seed[i] & width_mask(m_width[i]);
      if (v == 32'd0) v = width_mask(m_width[i]);
      m_state[i] = v;
      m_ref[i]   = v;
      m_wu[i]    = m_wu_par[i];
      m_wrap[i]  = 1'b0;
    end else if (m_wu[i] > 0) begin
      m_state[i] = model_step(m_state[i], m_width[i]);
      m_wu[i]    = m_wu[i] - 1;
      m_wrap[i]  = (m_state[i] == m_ref[i]);
    end else if (m_idx[i] >= 0) begin
      m_state[i] = model_step(m_state[i], m_width[i]);
      m_ptr[i]   = (m_idx[i] + 1) % 4;
      m_wrap[i]  = (m_state[i] == m_ref[i]);
    end else begin
      m_wrap[i] = 1'b0;
    end
  endtask

  task automatic model_check(input int i);
    logic [3:0] eg;
    int idx;
    if (rst) model_reset(i);
    eg = 4'd0;
    m_idx[i] = -1;
    if (!rst && !seed_load[i] && m_wu[i] == 0 && req[i] != 4'd0) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr[i] + k) % 4;
        if (m_idx[i] < 0 && req[i][idx]) m_idx[i] = idx;
      end
      eg = 4'd1 << m_idx[i];
    end
    chk("gnt", i, {28'd0, gnt_a[i]}, {28'd0, eg});
    if (eg != 4'd0) chk("rdata", i, rdata_a[i], m_state[i]);
    chk("busy", i, {31'd0, busy_a[i]}, {31'd0, (m_wu[i] > 0)});
    chk("period_wrap", i, {31'd0, wrap_a[i]}, {31'd0, m_wrap[i]});
  endtask

  // Compare process: model advances on each rising edge, checked on falling edge.
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_update(i);
      @(negedge clk);
      for (int i = 0; i < 3; i++) model_check(i);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] s;
    int first_f;
    int wraps;
    int nbusy;
    logic [3:0] exp_g;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 4'd0;
      seed_load[i] = 1'b0;
      seed[i] = 32'd0;
    end

    // Hand-computed pins on the model itself.
    s = model_step(32'hFFFF, 16);
    chk("pin_succ1", -1, s, 32'hFFFE);
    for (int k = 2; k <= 8; k++) begin
      s = model_step(s, 16);
      if (k == 5) chk("pin_succ5", -1, s, 32'hFFE1);
    end
    chk("pin_succ8", -1, s, 32'hFF0F);
    s = 32'hF;
    first_f = 0;
    for (int k = 1; k <= 20; k++) begin
      s = model_step(s, 4);
      if (s == 32'hF && first_f == 0) first_f = k;
    end
    chk("pin_period4", -1, first_f, 15);

    cyc();
    cyc();
    // Test 1: reset release with req=0001 held.
    rst = 1'b0;
    req[0] = 4'b0001;
    @(negedge clk);
    chk("t1_gnt", 0, {28'd0, gnt0}, 32'h1);
    chk("t1_rdata", 0, {16'd0, rdata0}, 32'hFFFF);
    @(negedge clk);
    chk("t1_next", 0, {16'd0, rdata0}, 32'hFFFE);

    // Bring the pointer back to 0, then test 2: all requesters.
    cyc();
    req[0] = 4'b1000;
    cyc();
    req[0] = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_g = 4'b0001 << (k % 4);
      chk("t2_gnt", 0, {28'd0, gnt0}, {28'd0, exp_g});
      if (k == 0) chk("t2_rdata0", 0, {16'd0, rdata0}, 32'hFFF8);
      if (k == 1) chk("t2_rdata1", 0, {16'd0, rdata0}, 32'hFFF0);
    end
    cyc();
    req[0] = 4'd0;

    // Test 3: 4-bit instance, continuous requests.
    cyc();
    req[1] = 4'b0001;
    @(negedge clk);
    chk("t3_start", 1, {28'd0, rdata1}, 32'hF);
    first_f = 0;
    wraps = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rdata1 == 4'hF && first_f == 0) first_f = k;
      if (wrap1) wraps++;
    end
    chk("t3_first_return", 1, first_f, 15);
    chk("t3_wrap_count", 1, wraps, 2);
    cyc();
    req[1] = 4'd0;

    // Test 4: zero seed, WARMUP=8, req held.
    cyc();
    req[0] = 4'b0001;
    seed[0] = 32'd0;
    seed_load[0] = 1'b1;
    @(negedge clk);
    chk("t4_gnt_on_load", 0, {28'd0, gnt0}, 32'h0);
    cyc();
    seed_load[0] = 1'b0;
    nbusy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy0) break;
      nbusy++;
      chk("t4_gnt_busy", 0, {28'd0, gnt0}, 32'h0);
    end
    chk("t4_busy_cycles", 0, nbusy, 8);
    chk("t4_first_gnt", 0, {28'd0, gnt0}, 32'h1);
    chk("t4_first_rdata", 0, {16'd0, rdata0}, 32'hFF0F);
    cyc();
    req[0] = 4'd0;

    // Test 5: seed_load beats req in the same cycle.
    cyc();
    seed[2] = 32'h1234;
    seed_load[2] = 1'b1;
    req[2] = 4'b0010;
    @(negedge clk);
    chk("t5_gnt_load", 2, {28'd0, gnt2}, 32'h0);
    cyc();
    seed_load[2] = 1'b0;
    @(negedge clk);
    chk("t5_gnt", 2, {28'd0, gnt2}, 32'h2);
    chk("t5_rdata", 2, {16'd0, rdata2}, 32'h1234);
    cyc();
    req[2] = 4'd0;

    // Test 6: reset in the 3rd warm-up cycle.
    cyc();
    seed[0] = 32'hBEEF;
    seed_load[0] = 1'b1;
    req[0] = 4'b0001;
    cyc();
    seed_load[0] = 1'b0;
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_gnt_rst", 0, {28'd0, gnt0}, 32'h0);
    chk("t6_busy_rst", 0, {31'd0, busy0}, 32'h0);
    chk("t6_rdata_rst", 0, {16'd0, rdata0}, 32'hFFFF);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_gnt_after", 0, {28'd0, gnt0}, 32'h1);
    chk("t6_rdata_after", 0, {16'd0, rdata0}, 32'hFFFF);
    cyc();
    req[0] = 4'd0;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
